// File: rtl/fp_mul_arb_pkg.sv
// Shared types and helpers for the round-robin float multiplier arbiter.
package fp_mul_arb_pkg;

  localparam int FP_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LAUNCH,
    WAIT,
    RESP
  } state_e;

  // Pointer advance with wrap: the slot after the one just served gets top priority.
  function automatic int next_ptr(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/fp_mul_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin : scan
    int c;
    logic found;
    logic [PTR_W-1:0] cidx;
    c     = 0;
    cidx  = '0;
    found = 1'b0;
    idx_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(ptr_i) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      cidx = PTR_W'(c);
      if (!found && req_i[cidx]) begin
        found = 1'b1;
        idx_o = cidx;
      end
    end
  end

  assign any_o  = |req_i;
  assign pick_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one 32-bit float multiplier among NUM_REQ requesters: grant, re-arm,
// launch, wait on done with a watchdog, then return the product to the owner.
module fp_mul_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [FP_W*NUM_REQ-1:0] req_x,
  input  logic [FP_W*NUM_REQ-1:0] req_y,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]         rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [FP_W-1:0]         mul_x,
  output logic [FP_W-1:0]         mul_y,
  output logic                    mul_rdy,
  output logic                    mul_rst_n,
  input  logic [FP_W-1:0]         mul_z,
  input  logic                    mul_done
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_e                 state_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       owner_q;
  logic [WD_W-1:0]        wd_q;
  logic [NUM_REQ-1:0]     gnt_q;
  logic [NUM_REQ-1:0]     rsp_valid_q;
  logic [FP_W-1:0]        rsp_data_q;
  logic                   rsp_err_q;
  logic                   busy_q;
  logic [FP_W-1:0]        mul_x_q;
  logic [FP_W-1:0]        mul_y_q;
  logic                   mul_rdy_q;
  logic                   mul_rst_n_q;

  logic [NUM_REQ-1:0]     pick_oh;
  logic [PTR_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [FP_W-1:0]        sel_x_d;
  logic [FP_W-1:0]        sel_y_d;
  logic [PTR_W-1:0]       ptr_d;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .pick_o (pick_oh),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign sel_x_d = req_x[FP_W*int'(pick_idx) +: FP_W];
  assign sel_y_d = req_y[FP_W*int'(pick_idx) +: FP_W];
  assign ptr_d   = PTR_W'(next_ptr(int'(owner_q), NUM_REQ));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      wd_q        <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      mul_rdy_q   <= 1'b0;
      mul_rst_n_q <= 1'b0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          mul_rst_n_q <= 1'b1;
          if (pick_any) begin
            owner_q <= pick_idx;
            mul_x_q <= sel_x_d;
            mul_y_q <= sel_y_d;
            gnt_q   <= pick_oh;
            busy_q  <= 1'b1;
            state_q <= ARM;
          end
        end
        // One-cycle re-arm clears the multiplier's sticky done before launch.
        ARM: begin
          mul_rst_n_q <= 1'b0;
          state_q     <= LAUNCH;
        end
        LAUNCH: begin
          mul_rst_n_q <= 1'b1;
          mul_rdy_q   <= 1'b1;
          wd_q        <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            rsp_data_q  <= mul_z;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= NUM_REQ'(1) << owner_q;
            mul_rdy_q   <= 1'b0;
            state_q     <= RESP;
          end else if (wd_q == WD_W'(TIMEOUT)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= NUM_REQ'(1) << owner_q;
            mul_rdy_q   <= 1'b0;
            state_q     <= RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        RESP: begin
          ptr_q   <= ptr_d;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign mul_rdy   = mul_rdy_q;
  assign mul_rst_n = mul_rst_n_q;

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Round-robin scheduler that shares one 32-bit float multiplier unit among NUM_REQ requesters (feedforward neurons).
- Captures one requester's operand pair and re-arms the multiplier before each operation.
- Launches the operation, waits for the unit's done flag with a watchdog, and returns the product to the owning requester.
- Sits between the neuron array and the single multiplier instance.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
TIMEOUT, 64, max cycles in WAIT before an error response (>=8)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester request level; hold with operands until gnt
req_x  in  32*NUM_REQ  operand x, requester i at bits [32i+31:32i]
req_y  in  32*NUM_REQ  operand y, same packing
gnt  out  NUM_REQ  one-hot, 1-cycle pulse: operands captured
rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse: result for requester i
rsp_data  out  32  product; valid only with rsp_valid
rsp_err  out  1  qualifies rsp_valid: watchdog expired, rsp_data=0
busy  out  1  high in every state except IDLE
mul_x  out  32  operand x to multiplier
mul_y  out  32  operand y to multiplier
mul_rdy  out  1  drives both multiplier x_rdy and y_rdy
mul_rst_n  out  1  active-low re-arm of multiplier
mul_z  in  32  multiplier result
mul_done  in  1  multiplier done; level, sticky until re-armed

Behaviour:
- Reset values (async, while rst_n=0):
  - gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
  - mul_x=0, mul_y=0, mul_rdy=0, mul_rst_n=0.
  - pointer=0, state=IDLE, watchdog=0.
- All outputs are registered.
- States: IDLE -> ARM -> LAUNCH -> WAIT -> RESP -> IDLE.
- IDLE:
  - mul_rst_n=1.
  - If any req: pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Latch owner, mul_x and mul_y from that requester's operands; pulse gnt[owner]; go ARM.
  - No req: stay in IDLE.
- ARM: mul_rst_n=0 for exactly one cycle; go LAUNCH.
- LAUNCH: mul_rst_n=1, mul_rdy=1, watchdog cleared; go WAIT.
- WAIT:
  - mul_rdy held at 1; watchdog increments each cycle.
  - mul_done=1: latch mul_z into rsp_data, rsp_err=0; go RESP. mul_done wins if it coincides with watchdog==TIMEOUT.
  - Else watchdog==TIMEOUT: rsp_data=0, rsp_err=1; go RESP.
- RESP:
  - rsp_valid[owner]=1 for one cycle; mul_rdy=0.
  - pointer = (owner+1) mod NUM_REQ; go IDLE.
- mul_done is ignored outside WAIT.
- Nominal latency, gnt to rsp_valid: 3 + N cycles, where N = cycles the multiplier takes to assert done after mul_rdy rises.
- Minimum spacing between two grants: 5 cycles.
- Requester rules:
  - The requester may drop req the cycle after gnt.
  - A req still high after gnt is treated as a new request at the next IDLE.
  - req falling before gnt is legal; that requester is simply skipped.
  - Operands are sampled only in the IDLE grant cycle; changes at any other time have no effect.
- Simultaneous requests: only one grant per IDLE visit. The pointer update guarantees every requester is served within NUM_REQ grants.
- Reset mid-operation:
  - Everything returns to reset values immediately; the in-flight result is discarded and no rsp_valid is issued.
  - mul_rst_n stays 0 until the first IDLE cycle after reset release.
- Widths: watchdog is clog2(TIMEOUT+1) bits; pointer and owner are clog2(NUM_REQ) bits.

Decomposition:
- Package fp_mul_arb_pkg holds:
  - FP_W=32.
  - State enum {IDLE, ARM, LAUNCH, WAIT, RESP}.
  - Helper function for the next-pointer wrap.
- Sub-module rr_picker (combinational):
  - Inputs: req vector, pointer.
  - Outputs: one-hot pick, pick index, any flag.
  - Verified standalone.

Test Plan:
- Single op: req[0], x=0x40000000, y=0x40400000; model done 8 cycles after mul_rdy -> gnt[0] in grant cycle, mul_rst_n low exactly 1 cycle, rsp_valid[0] with rsp_data=0x40C00000, rsp_err=0, 11 cycles after gnt.
- Sign product: req[2], x=0x3FC00000, y=0xC0000000 -> rsp_valid[2], rsp_data=0xC0400000.
- Round-robin: all 4 req asserted and held together -> grant order 0,1,2,3,0; each rsp_valid matches its own operands; no double grant.
- Fairness: req0 re-asserts right after its response while req2 is pending -> req2 granted before req0; pointer=3 after req2 completes.
- Watchdog: TIMEOUT=16, model never asserts done -> rsp_valid[owner] with rsp_err=1, rsp_data=0 after 16 WAIT cycles; next request completes normally.
- Reset in WAIT: rst_n low 2 cycles mid-operation -> all outputs at reset values, no rsp_valid, mul_rst_n=0; a fresh req[1] after release is granted first and produces a correct result.
